// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - registered N-channel round-robin arbitrating mux; packet lock under RR_ARB_MUX_LOCK_EN
module rr_arb_mux #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [N-1:0]    i_valid,
    output logic [N-1:0]    i_ready,
    input  logic [N*DW-1:0] i_data,
    input  logic [N-1:0]    i_last,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [DW-1:0]   o_data,
    output logic            o_last,
    output logic [N-1:0]    o_grant
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] cidx;
    logic [PW:0]   csum;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          ld;
    logic          xfer;
    logic          found;
    logic [DW-1:0] sel_data;
    logic          sel_last;

`ifdef RR_ARB_MUX_LOCK_EN
    logic          locked;
    logic [PW-1:0] lock_ch;

    // while a packet is open only its owning channel may compete
    always_comb begin
        req = i_valid;
        if (locked) begin
            req = i_valid & (N'(1) << lock_ch);
        end
    end
`else
    assign req = i_valid;
`endif

    // round-robin search upward from ptr, wrapping N-1 -> 0
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        csum  = '0;
        cidx  = '0;
        for (int k = 0; k < N; k++) begin
            csum = {1'b0, ptr} + (PW+1)'(k);
            if (csum >= (PW+1)'(N)) begin
                csum = csum - (PW+1)'(N);
            end
            cidx = csum[PW-1:0];
            if (!found && req[cidx]) begin
                found     = 1'b1;
                gnt[cidx] = 1'b1;
                gidx      = cidx;
            end
        end
    end

    assign ld      = !o_valid || o_ready;
    assign i_ready = gnt & {N{ld}} & {N{aresetn}};
    assign xfer    = |i_ready;
    assign ptr_inc = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;

    // one-hot AND-OR data select, no priority on the datapath
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int j = 0; j < N; j++) begin
            sel_data = sel_data | (i_data[j*DW +: DW] & {DW{gnt[j]}});
            sel_last = sel_last | (i_last[j] & gnt[j]);
        end
    end

    // one-entry output register: load on transfer, drain when consumer accepts
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_grant <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_data  <= sel_data;
            o_last  <= sel_last;
            o_grant <= gnt;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

    // priority pointer moves only on a transfer (and only at packet end when locking)
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ptr <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            locked  <= 1'b0;
            lock_ch <= '0;
`endif
        end else if (xfer) begin
`ifdef RR_ARB_MUX_LOCK_EN
            if (sel_last) begin
                locked <= 1'b0;
                ptr    <= ptr_inc;
            end else begin
                locked  <= 1'b1;
                lock_ch <= gidx;
            end
`else
            ptr <= ptr_inc;
`endif
        end
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Registered N-channel round-robin arbitrating multiplexer with valid/ready handshakes on every input and on the output. It is the sequential successor to the combinational one-hot mux: it generates its own one-hot grant, drives the same AND-OR data select internally, and holds the selected word in a one-entry output register. It sits wherever several producer streams share one consumer, e.g. request funnels and bus fan-in.

## Interface
- `DW`, 8, data width per channel (≥1)
- `N`, 4, number of input channels (≥2)

- `clk`  input  1  clock; all state on rising edge
- `aresetn`  input  1  asynchronous, active-low reset
- `i_valid`  input  N  per-channel word valid
- `i_ready`  output  N  per-channel accept; at most one bit high
- `i_data`  input  N*DW  channel j data at `[(j+1)*DW-1 -: DW]`
- `i_last`  input  N  per-channel end-of-packet flag
- `o_valid`  output  1  output register holds a word
- `o_ready`  input  1  consumer accept
- `o_data`  output  DW  registered word
- `o_last`  output  1  registered last flag
- `o_grant`  output  N  one-hot source channel of the current output word

## Operation
- Load enable: `ld = !o_valid || o_ready`.
- Arbiter: round-robin over `i_valid`, searching upward from pointer `ptr` and wrapping at N-1→0. It produces one-hot `gnt`, which is all-zero when no channel is valid.
- `i_ready = gnt & {N{ld}}`. It is forced to 0 while `aresetn` is low.
  - `i_ready` depends combinationally on `i_valid` and `o_ready`.
  - Producers must not make `i_valid` depend on `i_ready`.
- Transfer on channel g: `i_valid[g] && i_ready[g]`. On the next edge:
  - `o_data` is loaded with `i_data[g]`.
  - `o_last` is loaded with `i_last[g]`.
  - `o_grant` is loaded with `gnt`.
  - `o_valid` is set to 1.
  - `ptr` is set to (g+1) mod N.
- `ld` high with no channel valid, and `o_ready` high: `o_valid` goes to 0. `o_data`, `o_last` and `o_grant` hold their values.
- `o_valid` high with `o_ready` low: all output registers hold, and all `i_ready` are 0.
- `ptr` changes only on a transfer. Idle cycles do not rotate priority.
- Data select is a one-hot AND-OR of `gnt` against `i_data`. No priority encoding on the datapath.

## Timing
- Latency: 1 cycle from input transfer to `o_valid`.
- Throughput: 1 word/cycle sustained when `o_ready` is held high.
- Fairness: with all N channels continuously valid, grants rotate 0,1,…,N-1,0. Any waiting channel is served within N transfers (per-word mode).
- Reset (asynchronous assert, synchronous-to-`clk` deassert handled upstream):
  - `o_valid`=0, `o_data`=0, `o_last`=0, `o_grant`=0.
  - `ptr`=0, so channel 0 has highest priority.
  - Lock cleared.
- Reset mid-packet or mid-stall: the held word is dropped and no partial state survives.
- Wrap-around: after a transfer from channel N-1, `ptr`=0.
- Simultaneous drain and load (`o_valid && o_ready` and a transfer in the same cycle): the register is replaced, with no bubble.

## Configuration
- Macro: `RR_ARB_MUX_LOCK_EN`.
- Defined (packet lock):
  - A transfer from channel g with `i_last[g]`=0 sets lock to g.
  - While locked, `gnt` is restricted to channel g only. Other valid channels wait, even if g is idle, which inserts bubbles.
  - `ptr` does not advance while locked.
  - A transfer from g with `i_last[g]`=1 clears the lock and sets `ptr`=(g+1) mod N.
- Undefined: arbitration is per word, and `i_last` is only carried through to `o_last`. Lock logic is absent.

## Test plan
- Reset:
  - Stimulus: assert `aresetn`=0 with all `i_valid`=1.
  - Required: `o_valid`=0, `o_data`=0, `o_grant`=0, `i_ready`=0.
  - Stimulus: deassert reset with `o_ready`=1.
  - Required: first grant `i_ready`=4'b0001.
- Rotation:
  - Stimulus: N=4, all channels valid, channel j sends data 8'h10+j, `o_ready`=1.
  - Required: `o_data` sequence 10,11,12,13,10 on consecutive cycles, with `o_grant` 0001,0010,0100,1000,0001.
- Backpressure:
  - Stimulus: `o_ready`=0 for 5 cycles with a word held.
  - Required: `o_data`/`o_grant` stable, all `i_ready`=0.
  - Stimulus: raise `o_ready` while channel 2 is valid.
  - Required: next word from channel 2 loaded in the same cycle, no bubble.
- Sparse traffic:
  - Stimulus: only channel 3 valid, then only channel 1 valid.
  - Required: grants 1000 then 0010, `ptr` wraps to 0 after channel 3.
  - Stimulus: idle cycles.
  - Required: `o_valid`=0 and `ptr` unchanged.
- Lock (`RR_ARB_MUX_LOCK_EN`):
  - Stimulus: channel 1 sends 3 words with `last` on the third; channel 0 valid throughout.
  - Required: output 1,1,1 then 0.
  - Stimulus: channel 1 stalls `i_valid` mid-packet.
  - Required: channel 0 is not granted until channel 1's last word transfers.
- Reset mid-packet:
  - Stimulus: assert `aresetn` with lock held on channel 2.
  - Required: after release, channel 0 is granted first.
